mfp_ahb_7sd_scan_driver: RTL and testbench



---
 rtl/mfp_ahb_7sd_scan_driver.sv | 140 ++++++++++++++
 tb/tb_mfp_ahb_7sd_scan_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_7sd_scan_driver.sv
// Multiplexed seven-segment scan driver with blink, PWM brightness and blanking.
// Define MFP_7SD_SCAN_SKIP_EN to make disabled digits consume no scan slot.
module mfp_ahb_7sd_decoder (
    input  logic [5:0] seg_data,
    output logic [7:0] seg
);
    // seg_data = {dp_n, code}; segments are active-low, bit6 = a .. bit0 = g
    always_comb begin
        seg = {seg_data[5], 7'h7F};
        case (seg_data[4:0])
            5'h00:   seg[6:0] = 7'h01;
            5'h01:   seg[6:0] = 7'h4F;
            5'h02:   seg[6:0] = 7'h12;
            5'h03:   seg[6:0] = 7'h06;
            5'h04:   seg[6:0] = 7'h4C;
            5'h05:   seg[6:0] = 7'h24;
            5'h06:   seg[6:0] = 7'h20;
            5'h07:   seg[6:0] = 7'h0F;
            5'h08:   seg[6:0] = 7'h00;
            5'h09:   seg[6:0] = 7'h04;
            5'h0A:   seg[6:0] = 7'h08;
            5'h0B:   seg[6:0] = 7'h60;
            5'h0C:   seg[6:0] = 7'h31;
            5'h0D:   seg[6:0] = 7'h42;
            5'h0E:   seg[6:0] = 7'h30;
            5'h0F:   seg[6:0] = 7'h38;
            5'h11:   seg[6:0] = 7'h7E;
            default: seg[6:0] = 7'h7F;
        endcase
    end
endmodule

module mfp_ahb_7sd_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV_WIDTH    = 16,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_WIDTH  = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   EN,
    input  logic [5*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic [NUM_DIGITS-1:0]   BLINK,
    input  logic [3:0]              BRIGHT,
    output logic [NUM_DIGITS-1:0]   DISP_EN_OUT,
    output logic [7:0]              DISP_SEG_OUT
);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_WIDTH-1:0]   p_q, p_d;
    logic [SW-1:0]          s_q, s_d;
    logic [5:0]             c_q, c_d;
    logic [BLINK_WIDTH-1:0] b_q, b_d;
    logic [NUM_DIGITS-1:0]  en_out_q, en_out_d;
    logic [7:0]             seg_out_q, seg_out_d;

    logic                  slot_end, blanking, pwm_on;
    logic [NUM_DIGITS-1:0] anode_on;
    logic [5:0]            cur_code;
    logic [SW-1:0]         next_s;

    mfp_ahb_7sd_decoder u_dec (
        .seg_data (c_q),
        .seg      (seg_out_d)
    );

    always_comb begin
        cur_code = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (s_q == SW'(i)) cur_code = {~DP[i], DIGITS[5*i +: 5]};
        end
    end

`ifdef MFP_7SD_SCAN_SKIP_EN
    logic          found_any, found_after;
    logic [SW-1:0] lo_any, lo_after;

    // Cyclic search split in two: lowest enabled above s, else lowest enabled overall
    // (which may be s itself); with nothing enabled s holds.
    always_comb begin
        found_any   = 1'b0;
        found_after = 1'b0;
        lo_any      = s_q;
        lo_after    = s_q;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (EN[j] && !found_any) begin
                found_any = 1'b1;
                lo_any    = SW'(j);
            end
            if (EN[j] && (SW'(j) > s_q) && !found_after) begin
                found_after = 1'b1;
                lo_after    = SW'(j);
            end
        end
        next_s = found_after ? lo_after : lo_any;
    end
`else
    always_comb begin
        next_s = (s_q == SW'(NUM_DIGITS - 1)) ? '0 : s_q + 1'b1;
    end
`endif

    always_comb begin
        slot_end = &p_q;
        blanking = p_q < DIV_WIDTH'(BLANK_CYCLES);
        pwm_on   = p_q[DIV_WIDTH-1 -: 4] <= BRIGHT;
        p_d      = p_q + 1'b1;
        s_d      = slot_end ? next_s : s_q;
        c_d      = blanking ? cur_code : c_q;
        b_d      = b_q + 1'b1;
        anode_on = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            anode_on[i] = (s_q == SW'(i)) && EN[i] && !blanking && pwm_on
                          && !(BLINK[i] && b_q[BLINK_WIDTH-1]);
        end
        en_out_d = ~anode_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q       <= '0;
            s_q       <= '0;
            c_q       <= '0;
            b_q       <= '0;
            en_out_q  <= '1;
            seg_out_q <= '1;
        end else begin
            p_q       <= p_d;
            s_q       <= s_d;
            c_q       <= c_d;
            b_q       <= b_d;
            en_out_q  <= en_out_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign DISP_EN_OUT  = en_out_q;
    assign DISP_SEG_OUT = seg_out_q;
endmodule

// File: tb/tb_mfp_ahb_7sd_scan_driver.sv
// Self-checking bench for mfp_ahb_7sd_scan_driver: cycle-count based reference model,
// per-cycle compare, pinned scenario checks and a randomized phase.
module tb_mfp_ahb_7sd_scan_driver;
    localparam int ND = 5;
    localparam int DW = 4;
    localparam int BC = 2;
    localparam int BW = 6;
    localparam int SLOT = 1 << DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [ND-1:0]   EN = '1;
    logic [5*ND-1:0] DIGITS;
    logic [ND-1:0]   DP = '0;
    logic [ND-1:0]   BLINK = '0;
    logic [3:0]      BRIGHT = 4'hF;
    logic [ND-1:0]   DISP_EN_OUT;
    logic [7:0]      DISP_SEG_OUT;

    int checks = 0;
    int errors = 0;
    int tcount = 0;

    mfp_ahb_7sd_scan_driver #(
        .NUM_DIGITS   (ND),
        .DIV_WIDTH    (DW),
        .BLANK_CYCLES (BC),
        .BLINK_WIDTH  (BW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .EN           (EN),
        .DIGITS       (DIGITS),
        .DP           (DP),
        .BLINK        (BLINK),
        .BRIGHT       (BRIGHT),
        .DISP_EN_OUT  (DISP_EN_OUT),
        .DISP_SEG_OUT (DISP_SEG_OUT)
    );

    always #5 clk = ~clk;

    // Display glyphs as lit segments (a..g, a = MSB); pins are the inverse.
    function automatic logic [7:0] seg_of(input logic [5:0] c);
        logic [6:0] lit;
        case (c[4:0])
            5'h00: lit = 7'h7E;  5'h01: lit = 7'h30;  5'h02: lit = 7'h6D;  5'h03: lit = 7'h79;
            5'h04: lit = 7'h33;  5'h05: lit = 7'h5B;  5'h06: lit = 7'h5F;  5'h07: lit = 7'h70;
            5'h08: lit = 7'h7F;  5'h09: lit = 7'h7B;  5'h0A: lit = 7'h77;  5'h0B: lit = 7'h1F;
            5'h0C: lit = 7'h4E;  5'h0D: lit = 7'h3D;  5'h0E: lit = 7'h4F;  5'h0F: lit = 7'h47;
            5'h11: lit = 7'h01;
            default: lit = 7'h00;
        endcase
        return {c[5], ~lit};
    endfunction

    // Reference model: time since reset drives the prescaler and blink phase.
    int          m_t = 0;
    int          m_s = 0;
    logic [5:0]  m_c = '0;
    logic [ND-1:0] exp_en = '1;
    logic [7:0]  exp_seg = 8'hFF;
    bit          model_ok = 1'b0;

    function automatic int next_slot(input int s, input logic [ND-1:0] en);
`ifdef MFP_7SD_SCAN_SKIP_EN
        for (int k = 1; k <= ND; k++) begin
            if (en[(s + k) % ND]) return (s + k) % ND;
        end
        return s;
`else
        return (s + 1) % ND;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_s = 0; m_c = '0;
            exp_en = '1; exp_seg = 8'hFF;
            model_ok = 1'b1;
        end else begin
            int p;
            int blink_dark;
            p = m_t % SLOT;
            blink_dark = (m_t >> (BW - 1)) & 1;
            exp_seg = seg_of(m_c);
            exp_en = '1;
            if (p >= BC && EN[m_s] && (p >> (DW - 4)) <= int'(BRIGHT)
                && !(BLINK[m_s] && blink_dark == 1))
                exp_en[m_s] = 1'b0;
            if (p < BC) m_c = {~DP[m_s], DIGITS[5*m_s +: 5]};
            if (p == SLOT - 1) m_s = next_slot(m_s, EN);
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (DISP_EN_OUT !== exp_en) begin
                errors++;
                $display("FAIL en_out t=%0t got %b want %b", $time, DISP_EN_OUT, exp_en);
            end
            checks++;
            if (DISP_SEG_OUT !== exp_seg) begin
                errors++;
                $display("FAIL seg_out t=%0t got %h want %h", $time, DISP_SEG_OUT, exp_seg);
            end
            checks++;
            if ($countones(~DISP_EN_OUT) > 1) begin
                errors++;
                $display("FAIL one_anode t=%0t got %b want at most one low", $time, DISP_EN_OUT);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        tcount += n;
    endtask

    task automatic goto(input int t);
        tick(t - tcount);
    endtask

    initial begin
        int low0, lows, low1, low2;
        DIGITS = {5'h09, 5'h08, 5'h07, 5'h06, 5'h05};
        tick(3);
        chk("rst_en", int'(DISP_EN_OUT), 'h1F);
        chk("rst_seg", int'(DISP_SEG_OUT), 'hFF);
        rst = 1'b0;
        tcount = 0;

        low0 = 0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 2) chk("first_blank", int'(DISP_EN_OUT), 'h1F);
            if (k == 3) begin
                chk("first_lit_en", int'(DISP_EN_OUT), 'h1E);
                chk("first_lit_seg", int'(DISP_SEG_OUT), 'hA4);
            end
            if (!DISP_EN_OUT[0]) low0++;
        end
        chk("digit0_low_cycles", low0, 14);
        tick(1);
        chk("slot1_d0_off", int'(DISP_EN_OUT[0]), 1);

        goto(40);
        DIGITS[14:10] = 5'h0A;
        goto(47);
        chk("latch_hold", int'(DISP_SEG_OUT), 'h8F);
        goto(113);
        chk("blank_p0", int'(DISP_EN_OUT), 'h1F);
        goto(114);
        chk("blank_p1", int'(DISP_EN_OUT), 'h1F);
        goto(115);
        chk("new_code_en", int'(DISP_EN_OUT), 'h1B);
        chk("new_code_seg", int'(DISP_SEG_OUT), 'h88);

        goto(128);
        BRIGHT = 4'h7;
        lows = 0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (DISP_EN_OUT != '1) lows++;
        end
        chk("bright7_lows", lows, 6);
        BRIGHT = 4'h3;
        lows = 0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (DISP_EN_OUT != '1) lows++;
        end
        chk("bright3_lows", lows, 2);
        BRIGHT = 4'hF;

        goto(176);
        BLINK = 5'b00100;
        low1 = 0; low2 = 0;
        for (int k = 0; k < 192; k++) begin
            tick(1);
            if (!DISP_EN_OUT[1]) low1++;
            if (!DISP_EN_OUT[2]) low2++;
        end
        chk("blink_d2_lows", low2, 28);
        chk("blink_d1_lows", low1, 42);

        rst = 1'b1;
        tick(1);
        chk("midrst_en", int'(DISP_EN_OUT), 'h1F);
        chk("midrst_seg", int'(DISP_SEG_OUT), 'hFF);
        rst = 1'b0;
        tcount = 0;
        tick(2);
        chk("restart_blank", int'(DISP_EN_OUT), 'h1F);
        tick(1);
        chk("restart_d0", int'(DISP_EN_OUT), 'h1E);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) DIGITS = 25'($urandom);
            if ($urandom_range(0, 15) == 0) DP = 5'($urandom);
            if ($urandom_range(0, 63) == 0) EN = 5'($urandom);
            if ($urandom_range(0, 63) == 0) BLINK = 5'($urandom);
            if ($urandom_range(0, 31) == 0) BRIGHT = 4'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        rst = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
